// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and stall/flush controls for the hazard unit
interface hazard_ctrl_if;
    logic [4:0]  rs1_D, rs2_D, rd_E, rd_M, rd_W;
    logic        use1_D, use2_D, regWrite_E, regWrite_M, regWrite_W, PCSrc_M;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, stall;
    logic [31:0] stall_cnt, flush_cnt;
    modport master (
        output rs1_D, rs2_D, rd_E, rd_M, rd_W, use1_D, use2_D,
               regWrite_E, regWrite_M, regWrite_W, PCSrc_M,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, stall,
               stall_cnt, flush_cnt
    );
    modport slave (
        input  rs1_D, rs2_D, rd_E, rd_M, rd_W, use1_D, use2_D,
               regWrite_E, regWrite_M, regWrite_W, PCSrc_M,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, stall,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall and branch flush control for a 5-stage pipeline without forwarding
module hazard_ctrl (
    input logic clk,
    input logic reset,
    hazard_ctrl_if.slave h
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    state_t      state;
    logic [1:0]  rem, n;
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        hit_e, hit_m, hit_w, hz, br;

    function automatic logic hit(logic u, logic w, logic [4:0] rd, logic [4:0] rs);
        return u & w & (rd == rs) & (rd != 5'd31);
    endfunction

    assign hit_e = hit(h.use1_D, h.regWrite_E, h.rd_E, h.rs1_D) | hit(h.use2_D, h.regWrite_E, h.rd_E, h.rs2_D);
    assign hit_m = hit(h.use1_D, h.regWrite_M, h.rd_M, h.rs1_D) | hit(h.use2_D, h.regWrite_M, h.rd_M, h.rs2_D);
    assign hit_w = hit(h.use1_D, h.regWrite_W, h.rd_W, h.rs1_D) | hit(h.use2_D, h.regWrite_W, h.rd_W, h.rs2_D);

    // nearest producer decides how many bubbles are still needed
    always_comb begin
        n = hit_e ? 2'd3 : hit_m ? 2'd2 : hit_w ? 2'd1 : 2'd0;
    end

    assign br = !reset && h.PCSrc_M;
    assign hz = !reset && !h.PCSrc_M && (state == STALL || (state == RUN && n != 2'd0));

    assign h.stall        = hz;
    assign h.pc_en        = !hz;
    assign h.if_id_en     = !hz;
    assign h.if_id_flush  = br;
    assign h.id_ex_flush  = hz | br;
    assign h.ex_mem_flush = br;
    assign h.stall_cnt    = stall_cnt_q;
    assign h.flush_cnt    = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            rem         <= 2'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (h.PCSrc_M) begin
                state <= FLUSH;
                rem   <= 2'd0;
            end else begin
                case (state)
                    RUN: begin
                        state <= (n >= 2'd2) ? STALL : RUN;
                        rem   <= (n >= 2'd2) ? n - 2'd1 : 2'd0;
                    end
                    STALL: begin
                        state <= (rem <= 2'd1) ? RUN : STALL;
                        rem   <= (rem == 2'd0) ? 2'd0 : rem - 2'd1;
                    end
                    default: begin
                        state <= RUN;
                        rem   <= 2'd0;
                    end
                endcase
            end
            if (hz && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (h.PCSrc_M && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall/flush sequencing, counters and reset
module tb_hazard_ctrl;
    logic clk, reset;
    int   checks, errors;
    hazard_ctrl_if hif ();
    hazard_ctrl dut (.clk(clk), .reset(reset), .h(hif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hif.rs1_D = 5'd0; hif.rs2_D = 5'd0; hif.use1_D = 1'b0; hif.use2_D = 1'b0;
        hif.rd_E = 5'd0; hif.rd_M = 5'd0; hif.rd_W = 5'd0;
        hif.regWrite_E = 1'b0; hif.regWrite_M = 1'b0; hif.regWrite_W = 1'b0;
        hif.PCSrc_M = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic hz_e();
        clr();
        hif.rs1_D = 5'd3; hif.use1_D = 1'b1; hif.rd_E = 5'd3; hif.regWrite_E = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        clr();
        tick();
        #1;
        chk("rst_pc_en", {31'd0, hif.pc_en}, 32'd1);
        chk("rst_stall", {31'd0, hif.stall}, 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_stall_cnt", hif.stall_cnt, 32'd0);
        chk("rst_flush_cnt", hif.flush_cnt, 32'd0);
        chk("idle_flushes", {29'd0, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush}, 32'd0);
        chk("idle_if_id_en", {31'd0, hif.if_id_en}, 32'd1);

        // E-stage producer: three bubbles
        do_reset();
        hz_e();
        #1;
        chk("e_ctrl", {28'd0, hif.stall, hif.pc_en, hif.if_id_en, hif.id_ex_flush}, 32'b1001);
        tick();
        for (int i = 1; i < 3; i++) begin
            chk("e_stall", {31'd0, hif.stall}, 32'd1);
            tick();
        end
        clr();
        #1;
        chk("e_done_stall", {31'd0, hif.stall}, 32'd0);
        chk("e_done_pc_en", {31'd0, hif.pc_en}, 32'd1);
        chk("e_stall_cnt", hif.stall_cnt, 32'd3);

        // M-stage producer wins since E does not write
        do_reset();
        hif.rs2_D = 5'd5; hif.use2_D = 1'b1; hif.rd_M = 5'd5; hif.regWrite_M = 1'b1;
        hif.rd_E = 5'd5; hif.regWrite_E = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("m_stall", {31'd0, hif.stall}, 32'd1);
            tick();
        end
        clr();
        #1;
        chk("m_done_stall", {31'd0, hif.stall}, 32'd0);
        chk("m_stall_cnt", hif.stall_cnt, 32'd2);

        // W-stage producer: one bubble, stays in RUN
        do_reset();
        hif.rs2_D = 5'd5; hif.use2_D = 1'b1; hif.rd_W = 5'd5; hif.regWrite_W = 1'b1;
        hif.rd_E = 5'd5; hif.regWrite_E = 1'b0;
        #1;
        chk("w_stall", {31'd0, hif.stall}, 32'd1);
        tick();
        clr();
        #1;
        chk("w_done_stall", {31'd0, hif.stall}, 32'd0);
        chk("w_stall_cnt", hif.stall_cnt, 32'd1);

        // XZR and unused operand never stall
        do_reset();
        hif.rs1_D = 5'd31; hif.use1_D = 1'b1; hif.rd_E = 5'd31; hif.regWrite_E = 1'b1;
        #1;
        chk("xzr_stall", {31'd0, hif.stall}, 32'd0);
        tick();
        hz_e();
        hif.use1_D = 1'b0;
        #1;
        chk("nouse_stall", {31'd0, hif.stall}, 32'd0);
        tick();

        // branch aborts a stall in progress
        do_reset();
        hz_e();
        #1;
        chk("br_stall1", {31'd0, hif.stall}, 32'd1);
        tick();
        hif.PCSrc_M = 1'b1;
        #1;
        chk("br_flushes", {29'd0, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush}, 32'b111);
        chk("br_ctrl", {29'd0, hif.stall, hif.pc_en, hif.if_id_en}, 32'b011);
        tick();
        hif.PCSrc_M = 1'b0;
        #1;
        chk("flush_state_stall", {31'd0, hif.stall}, 32'd0);
        chk("flush_state_flushes", {29'd0, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush}, 32'd0);
        tick();
        #1;
        chk("run_after_flush", {31'd0, hif.stall}, 32'd1);
        chk("br_flush_cnt", hif.flush_cnt, 32'd1);
        chk("br_stall_cnt", hif.stall_cnt, 32'd1);

        // back-to-back branches: re-flush, one extra FLUSH cycle
        do_reset();
        hif.PCSrc_M = 1'b1;
        tick();
        hz_e();
        hif.PCSrc_M = 1'b1;
        #1;
        chk("reflush", {29'd0, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush}, 32'b111);
        tick();
        hif.PCSrc_M = 1'b0;
        #1;
        chk("reflush_hold", {31'd0, hif.stall}, 32'd0);
        tick();
        #1;
        chk("reflush_run", {31'd0, hif.stall}, 32'd1);
        chk("reflush_cnt", hif.flush_cnt, 32'd2);

        // stall counter saturation
        do_reset();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        hz_e();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sat_stall", {31'd0, hif.stall}, 32'd1);
            tick();
        end
        clr();
        #1;
        chk("sat_cnt", hif.stall_cnt, 32'hFFFF_FFFF);

        // reset during the second stall cycle
        do_reset();
        hz_e();
        tick();
        reset = 1'b1;
        hif.PCSrc_M = 1'b1;
        #1;
        chk("rst_mid_ctrl", {26'd0, hif.stall, hif.pc_en, hif.if_id_en, hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush}, 32'b011000);
        tick();
        reset = 1'b0;
        clr();
        #1;
        chk("rst_mid_stall", {31'd0, hif.stall}, 32'd0);
        chk("rst_mid_stall_cnt", hif.stall_cnt, 32'd0);
        chk("rst_mid_flush_cnt", hif.flush_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
